cpld_bank_sel_capture: RTL and testbench



---
 rtl/cpld_bank_sel_capture.sv | 146 ++++++++++++++
 tb/tb_cpld_bank_sel_capture.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cpld_bank_sel_capture.sv
// Synchronous capture of Z80 OUT (0x7Fxx),data writes with data[7:6]=11 into a
// glitch-qualified 6-bit RAM bank/scheme value. Define DEFER_EN to hold commits until MREQ is idle.
module cpld_bank_sel_capture #(
  parameter int         QUAL_CYCLES = 2,
  parameter logic [5:0] RESET_BLOCK = 6'b000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iorq_b,
  input  logic       wr_b,
  input  logic       m1_b,
  input  logic       adr15,
  input  logic       mreq_b,
  input  logic [7:0] data,
  output logic [5:0] ramblock,
  output logic       ramblock_upd,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, QUAL, HOLD} state_t;

  localparam logic [2:0] QUAL_N = 3'(QUAL_CYCLES);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [5:0] dlat_q, dlat_d;
  logic [5:0] ramblock_q, ramblock_d;
  logic       upd_q, upd_d;
  logic       busy_q, busy_d;
  logic       valid;
  logic       commit;
  logic [5:0] commitVal;

`ifdef DEFER_EN
  logic       pend_q, pend_d;
  logic [5:0] pending_q, pending_d;
`else
  logic       unused_mreq;
  assign unused_mreq = mreq_b;
`endif

  assign valid = !iorq_b && !wr_b && m1_b && !adr15 && data[7] && data[6];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dlat_d    = dlat_q;
    commit    = 1'b0;
    commitVal = dlat_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          dlat_d = data[5:0];
          cnt_d  = 3'd1;
          if (QUAL_CYCLES == 1) begin
            commit    = 1'b1;
            commitVal = data[5:0];
            state_d   = HOLD;
          end else begin
            state_d = QUAL;
          end
        end
      end
      QUAL: begin
        if (!valid) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else if (data[5:0] != dlat_q) begin
          // Data moved under a valid strobe: restart qualification on the new value
          dlat_d = data[5:0];
          cnt_d  = 3'd1;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if ((cnt_q + 3'd1) == QUAL_N) begin
            commit  = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // One commit per I/O cycle: wait for IORQ to go away before re-arming
        if (iorq_b) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ramblock_d = ramblock_q;
    upd_d      = 1'b0;
`ifdef DEFER_EN
    pend_d    = pend_q;
    pending_d = pending_q;
    // A fresh commit overwrites any pending value; application waits for MREQ high
    if (commit) begin
      pending_d = commitVal;
      pend_d    = 1'b1;
    end else if (pend_q && mreq_b) begin
      ramblock_d = pending_q;
      upd_d      = 1'b1;
      pend_d     = 1'b0;
    end
    busy_d = (state_d != IDLE) || pend_d;
`else
    if (commit) begin
      ramblock_d = commitVal;
      upd_d      = 1'b1;
    end
    busy_d = (state_d != IDLE);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      dlat_q     <= 6'd0;
      ramblock_q <= RESET_BLOCK;
      upd_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef DEFER_EN
      pend_q     <= 1'b0;
      pending_q  <= 6'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dlat_q     <= dlat_d;
      ramblock_q <= ramblock_d;
      upd_q      <= upd_d;
      busy_q     <= busy_d;
`ifdef DEFER_EN
      pend_q     <= pend_d;
      pending_q  <= pending_d;
`endif
    end
  end

  assign ramblock     = ramblock_q;
  assign ramblock_upd = upd_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_cpld_bank_sel_capture.sv
// Scoreboard bench for cpld_bank_sel_capture: expected bank values are queued by the
// stimulus and consumed by a monitor on every ramblock_upd pulse.
module tb_cpld_bank_sel_capture;

  logic       clk;
  logic       reset;
  logic       iorq_b;
  logic       wr_b;
  logic       m1_b;
  logic       adr15;
  logic       mreq_b;
  logic [7:0] data;
  logic [5:0] ramblock;
  logic       ramblock_upd;
  logic       busy;

  int total = 0;
  int bad   = 0;
  logic [5:0] expQ[$];

  cpld_bank_sel_capture #(.QUAL_CYCLES(2), .RESET_BLOCK(6'b000000)) dut (
    .clk(clk),
    .reset(reset),
    .iorq_b(iorq_b),
    .wr_b(wr_b),
    .m1_b(m1_b),
    .adr15(adr15),
    .mreq_b(mreq_b),
    .data(data),
    .ramblock(ramblock),
    .ramblock_upd(ramblock_upd),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every update pulse must match the oldest expected value
  always @(negedge clk) begin
    if (!reset && ramblock_upd) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_upd: got ramblock=%0h, required no update", ramblock);
      end else begin
        logic [5:0] e;
        e = expQ.pop_front();
        if (ramblock !== e) begin
          bad++;
          $display("[TB] FAIL upd_value: got %0h required %0h", ramblock, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iorq, input logic wr, input logic m1,
                               input logic a15, input logic [7:0] d);
    iorq_b = iorq;
    wr_b   = wr;
    m1_b   = m1;
    adr15  = a15;
    data   = d;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic idleBus();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    reset  = 1'b1;
    mreq_b = 1'b1;
    idleBus();
    tick();
    tick();
    checkOutput("reset_ramblock", {2'b0, ramblock}, 8'h00);
    checkOutput("reset_upd", {7'b0, ramblock_upd}, 8'h00);
    checkOutput("reset_busy", {7'b0, busy}, 8'h00);
    reset = 1'b0;
    tick();

    // OUT 0x7F00,0xC2 held three clocks
    expQ.push_back(6'h02);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'hC2);
    tick();
    checkOutput("qual_busy", {7'b0, busy}, 8'h01);
    checkOutput("qual_no_commit_yet", {2'b0, ramblock}, 8'h00);
    tick();
    tick();
    checkOutput("commit_c2", {2'b0, ramblock}, 8'h02);
    checkOutput("hold_busy", {7'b0, busy}, 8'h01);
    idleBus();
    tick();
    checkOutput("busy_drop_after_iorq", {7'b0, busy}, 8'h00);
    tick();

    // Unstable data: 0xC1 then 0xC3 held, only 0x03 commits
    expQ.push_back(6'h03);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'hC1);
    tick();
    data = 8'hC3;
    tick();
    tick();
    tick();
    idleBus();
    tick();
    tick();
    checkOutput("commit_c3", {2'b0, ramblock}, 8'h03);

    // Other gate-array functions and wrong port are ignored
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h8A);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("ignore_8a_busy", {7'b0, busy}, 8'h00);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'hC4);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("ignore_adr15_busy", {7'b0, busy}, 8'h00);
    end
    idleBus();
    tick();
    checkOutput("ignored_ramblock", {2'b0, ramblock}, 8'h03);

    // One-clock IORQ glitch aborts qualification
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'hC7);
    tick();
    idleBus();
    tick();
    checkOutput("glitch_abort_busy", {7'b0, busy}, 8'h00);
    // Interrupt acknowledge (M1 low) never qualifies
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'hC7);
    tick();
    tick();
    tick();
    checkOutput("m1_busy", {7'b0, busy}, 8'h00);
    idleBus();
    tick();
    checkOutput("glitch_ramblock", {2'b0, ramblock}, 8'h03);

    // Re-committing the same value still pulses; long cycle gives a single pulse
    expQ.push_back(6'h03);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'hC3);
    for (int i = 0; i < 6; i++) tick();
    idleBus();
    tick();
    tick();

    // All-ones bank field
    expQ.push_back(6'h3F);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF);
    tick();
    tick();
    tick();
    idleBus();
    tick();
    tick();
    checkOutput("commit_ff", {2'b0, ramblock}, 8'h3F);

`ifdef DEFER_EN
    // Commit while MREQ busy stays pending until MREQ is sampled high
    expQ.push_back(6'h0A);
    mreq_b = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'hCA);
    tick();
    tick();
    idleBus();
    tick();
    tick();
    tick();
    tick();
    checkOutput("defer_hold_old", {2'b0, ramblock}, 8'h3F);
    checkOutput("defer_busy", {7'b0, busy}, 8'h01);
    mreq_b = 1'b1;
    tick();
    checkOutput("defer_apply", {2'b0, ramblock}, 8'h0A);
    tick();
    checkOutput("defer_busy_clear", {7'b0, busy}, 8'h00);
`endif

    // Asynchronous reset mid-qualification
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'hC5);
    tick();
    checkOutput("midqual_busy", {7'b0, busy}, 8'h01);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_ramblock", {2'b0, ramblock}, 8'h00);
    checkOutput("async_rst_busy", {7'b0, busy}, 8'h00);
    checkOutput("async_rst_upd", {7'b0, ramblock_upd}, 8'h00);
    idleBus();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("post_rst_ramblock", {2'b0, ramblock}, 8'h00);
    checkOutput("post_rst_busy", {7'b0, busy}, 8'h00);

    tick();
    checkOutput("scoreboard_drained", 8'(expQ.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
